// File: rtl/window_row_ctrl_if.sv
// Bus bundle between window_row_ctrl and its three neighbours: BRAM port B,
// the 3-pixel window byte FIFO and the downstream processing stage.
interface window_row_ctrl_if;
   logic        enb;
   logic [7:0]  addrb;
   logic [63:0] doutb;
   logic [63:0] fifo_data_in;
   logic        fifo_push;
   logic        fifo_pop;
   logic        fifo_one_row_complete;
   logic [23:0] fifo_data_o;
   logic [3:0]  fifo_count;
   logic [23:0] window_data;
   logic        window_valid;
   logic        window_ready;

   modport master (
      output enb, addrb, fifo_data_in, fifo_push, fifo_pop, fifo_one_row_complete,
             window_data, window_valid,
      input  doutb, fifo_data_o, fifo_count, window_ready
   );

   modport slave (
      input  enb, addrb, fifo_data_in, fifo_push, fifo_pop, fifo_one_row_complete,
             window_data, window_valid,
      output doutb, fifo_data_o, fifo_count, window_ready
   );
endinterface

// File: rtl/window_row_ctrl.sv
// Row sequencer: streams image rows from BRAM into the window byte FIFO and
// hands 24-bit windows to the processing stage, clearing the FIFO between rows.
module window_row_ctrl #(
   parameter int ROW_WORDS = 2,
   parameter int NUM_ROWS  = 2,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [7:0]        row_idx,
   output logic [7:0]        col_idx,
   window_row_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, ROW_END, DONE} state_e;

   localparam logic [5:0] ROW_WORDS_W     = 6'(ROW_WORDS);
   localparam logic [7:0] WINDOWS_PER_ROW = 8'(8 * ROW_WORDS - 2);
   localparam logic [7:0] LAST_ROW        = 8'(NUM_ROWS - 1);
   localparam logic [7:0] BASE            = 8'(BASE_ADDR);

   state_e     state_q, state_d;
   logic [5:0] words_issued_q, words_issued_d;
   logic [7:0] windows_left_q, windows_left_d;
   logic [7:0] row_idx_q, row_idx_d;
   logic [7:0] col_idx_q, col_idx_d;
   logic [7:0] addrb_q, addrb_d;
   logic       enb_q, enb_d;
   logic       in_flight_q, in_flight_d;
   logic       clr_q, clr_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       window_valid;
   logic       pop;

   assign window_valid = (state_q == RUN) && (bus.fifo_count >= 4'd3) && (windows_left_q != 8'd0);
   assign pop          = window_valid && bus.window_ready;

   always_comb begin
      // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
      state_d        = state_q;
      words_issued_d = words_issued_q;
      windows_left_d = windows_left_q;
      row_idx_d      = row_idx_q;
      col_idx_d      = col_idx_q;
      addrb_d        = addrb_q;
      enb_d          = 1'b0;
      in_flight_d    = enb_q;
      clr_d          = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d        = RUN;
               clr_d          = 1'b1;
               words_issued_d = 6'd0;
               windows_left_d = WINDOWS_PER_ROW;
               row_idx_d      = 8'd0;
               col_idx_d      = 8'd0;
            end
         end
         RUN: begin
            // Issue only with nothing outstanding and room for a full word, so a push can never overflow.
            if ((words_issued_q < ROW_WORDS_W) && !enb_q && !in_flight_q && !bus.fifo_count[3]) begin
               enb_d          = 1'b1;
               addrb_d        = BASE + 8'(row_idx_q * ROW_WORDS) + {2'b00, words_issued_q};
               words_issued_d = words_issued_q + 6'd1;
            end
            if (pop) begin
               windows_left_d = windows_left_q - 8'd1;
               if (windows_left_q == 8'd1) begin
                  state_d = ROW_END;
                  clr_d   = 1'b1;
               end else begin
                  col_idx_d = col_idx_q + 8'd1;
               end
            end
         end
         ROW_END: begin
            if (row_idx_q == LAST_ROW) begin
               state_d = DONE;
            end else begin
               state_d        = RUN;
               row_idx_d      = row_idx_q + 8'd1;
               col_idx_d      = 8'd0;
               words_issued_d = 6'd0;
               windows_left_d = WINDOWS_PER_ROW;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == ROW_END);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         words_issued_q <= 6'd0;
         windows_left_q <= 8'd0;
         row_idx_q      <= 8'd0;
         col_idx_q      <= 8'd0;
         addrb_q        <= 8'd0;
         enb_q          <= 1'b0;
         in_flight_q    <= 1'b0;
         clr_q          <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         // NOTE: non-blocking updates make every flop sample the same pre-edge values.
         state_q        <= state_d;
         words_issued_q <= words_issued_d;
         windows_left_q <= windows_left_d;
         row_idx_q      <= row_idx_d;
         col_idx_q      <= col_idx_d;
         addrb_q        <= addrb_d;
         enb_q          <= enb_d;
         in_flight_q    <= in_flight_d;
         clr_q          <= clr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
      end
   end

   assign bus.enb                   = enb_q;
   assign bus.addrb                 = addrb_q;
   assign bus.fifo_push             = in_flight_q;
   assign bus.fifo_data_in          = in_flight_q ? bus.doutb : 64'h0;
   assign bus.fifo_pop              = pop;
   assign bus.fifo_one_row_complete = clr_q;
   assign bus.window_valid          = window_valid;
   assign bus.window_data           = window_valid ? bus.fifo_data_o : 24'h0;
   assign busy                      = busy_q;
   assign done                      = done_q;
   assign row_idx                   = row_idx_q;
   assign col_idx                   = col_idx_q;
endmodule

// File: tb/tb_window_row_ctrl.sv
// Scoreboard bench for window_row_ctrl: two instances (default and a wrapping
// one-word-row configuration) with behavioural BRAM and window-FIFO models.
module tb_window_row_ctrl;
   typedef struct packed {
      logic [7:0]  row;
      logic [7:0]  col;
      logic [23:0] data;
   } win_t;

   localparam int RW_C   [2] = '{2, 1};
   localparam int NR_C   [2] = '{2, 3};
   localparam int BASE_C [2] = '{0, 254};

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_s [2];
   logic       busy_s  [2];
   logic       done_s  [2];
   logic [7:0] row_s   [2];
   logic [7:0] col_s   [2];

   window_row_ctrl_if bus [2] ();

   logic [63:0]  mem [256];
   win_t         exp_win  [2][$];
   logic [7:0]   exp_addr [2][$];
   int           pops_seen [2];
   int           clears_seen [2];
   int           dones_seen [2];
   logic [118:0] out_vec [2];
   int           tests = 0;
   int           fails = 0;
   int           ready_mode = 0;
   int           stall_left = 0;
   logic         rdy;

   always #5 clk = ~clk;

   window_row_ctrl #(.ROW_WORDS(RW_C[0]), .NUM_ROWS(NR_C[0]), .BASE_ADDR(BASE_C[0])) u_dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
      .row_idx(row_s[0]), .col_idx(col_s[0]), .bus(bus[0])
   );

   window_row_ctrl #(.ROW_WORDS(RW_C[1]), .NUM_ROWS(NR_C[1]), .BASE_ADDR(BASE_C[1])) u_dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
      .row_idx(row_s[1]), .col_idx(col_s[1]), .bus(bus[1])
   );

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_env
      logic [7:0]  fq [$];
      logic        cap_push, cap_pop, cap_clr;
      logic [63:0] cap_din;
      logic        prev_enb = 1'b0;
      logic        prev_stall = 1'b0;
      logic [23:0] prev_data = 24'h0;

      assign out_vec[g] = {busy_s[g], done_s[g], bus[g].enb, bus[g].addrb, bus[g].fifo_data_in,
                           bus[g].fifo_push, bus[g].fifo_pop, bus[g].fifo_one_row_complete,
                           bus[g].window_data, bus[g].window_valid, row_s[g], col_s[g]};

      // BRAM port B: registered read, contents not affected by reset.
      always @(posedge clk) if (bus[g].enb) bus[g].doutb <= mem[bus[g].addrb];

      always @(negedge clk) begin
         cap_push = bus[g].fifo_push;
         cap_pop  = bus[g].fifo_pop;
         cap_clr  = bus[g].fifo_one_row_complete;
         cap_din  = bus[g].fifo_data_in;
      end

      // Window FIFO: byte queue, pixel 0 of a word is its low byte, head window = {q2,q1,q0}.
      always @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            fq.delete();
         end else if (cap_clr) begin
            fq.delete();
         end else begin
            if (cap_pop && fq.size() > 0) void'(fq.pop_front());
            if (cap_push) begin
               for (int b = 0; b < 8; b++) fq.push_back(cap_din[8*b +: 8]);
               check("fifo_no_overflow", fq.size() <= 15, 1'b1);
            end
         end
         bus[g].fifo_count  <= 4'(fq.size());
         bus[g].fifo_data_o <= (fq.size() >= 3) ? {fq[2], fq[1], fq[0]} : 24'h0;
      end

      always @(negedge clk) begin
         win_t e;
         if (reset_n) begin
            if (bus[g].fifo_pop) begin
               pops_seen[g]++;
               check("pop_expected", exp_win[g].size() != 0, 1'b1);
               if (exp_win[g].size() != 0) begin
                  e = exp_win[g].pop_front();
                  check("window", {row_s[g], col_s[g], bus[g].window_data}, e);
               end
            end
            if (bus[g].enb) begin
               check("enb_fifo_room", bus[g].fifo_count <= 4'd7, 1'b1);
               check("read_expected", exp_addr[g].size() != 0, 1'b1);
               if (exp_addr[g].size() != 0) check("addrb", bus[g].addrb, exp_addr[g].pop_front());
            end
            if (bus[g].fifo_push || prev_enb) check("push_timing", bus[g].fifo_push, prev_enb);
            if (prev_stall) check("stall_hold", {bus[g].window_valid, bus[g].window_data}, {1'b1, prev_data});
            if (bus[g].fifo_one_row_complete) clears_seen[g]++;
            if (done_s[g]) begin
               dones_seen[g]++;
               check("busy_low_at_done", busy_s[g], 1'b0);
            end
            prev_enb   = bus[g].enb;
            prev_stall = bus[g].window_valid && !bus[g].window_ready;
            prev_data  = bus[g].window_data;
         end else begin
            prev_enb   = 1'b0;
            prev_stall = 1'b0;
         end
      end
   end

   // Ready generator: 0 always, 1 random, 2 toggle, 3 hold low 20 cycles after the first valid.
   initial begin
      rdy = 1'b1;
      bus[0].window_ready = 1'b1;
      bus[1].window_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1: rdy = 1'($urandom_range(0, 1));
            2: rdy = ~rdy;
            3: begin
               if (stall_left > 0) begin
                  rdy = 1'b0;
                  if (bus[0].window_valid || stall_left < 20) stall_left--;
               end else begin
                  rdy = 1'b1;
               end
            end
            default: rdy = 1'b1;
         endcase
         bus[0].window_ready = rdy;
         bus[1].window_ready = rdy;
      end
   end

   // Reference: each row is a pixel stream of 8*ROW_WORDS bytes; window k = pixels k..k+2.
   task automatic expect_frame(input int d);
      logic [7:0] px [$];
      logic [7:0] a;
      win_t       e;
      for (int r = 0; r < NR_C[d]; r++) begin
         px.delete();
         for (int w = 0; w < RW_C[d]; w++) begin
            a = 8'(BASE_C[d] + r * RW_C[d] + w);
            exp_addr[d].push_back(a);
            for (int b = 0; b < 8; b++) px.push_back(mem[a][8*b +: 8]);
         end
         for (int k = 0; k < 8 * RW_C[d] - 2; k++) begin
            e.row  = 8'(r);
            e.col  = 8'(k);
            e.data = {px[k+2], px[k+1], px[k]};
            exp_win[d].push_back(e);
         end
      end
   endtask

   task automatic pulse_start(input int d);
      @(posedge clk);
      #1 start_s[d] = 1'b1;
      @(posedge clk);
      #1 start_s[d] = 1'b0;
   endtask

   task automatic run_frame(input int d, input int mode, input bit extra_start);
      int cyc;
      expect_frame(d);
      pops_seen[d]   = 0;
      clears_seen[d] = 0;
      dones_seen[d]  = 0;
      ready_mode     = mode;
      stall_left     = 20;
      pulse_start(d);
      check("busy_after_start", busy_s[d], 1'b1);
      cyc = 0;
      while (dones_seen[d] == 0 && cyc < 2000) begin
         @(posedge clk);
         #1;
         cyc++;
         start_s[d] = extra_start && (cyc == 12);
      end
      start_s[d] = 1'b0;
      check("done_in_time", dones_seen[d] != 0, 1'b1);
      repeat (4) @(negedge clk);
      check("done_pulses", dones_seen[d], 1);
      check("clear_pulses", clears_seen[d], NR_C[d] + 1);
      check("pop_total", pops_seen[d], NR_C[d] * (8 * RW_C[d] - 2));
      check("windows_left_over", exp_win[d].size(), 0);
      check("reads_left_over", exp_addr[d].size(), 0);
   endtask

   initial begin
      int cyc;
      reset_n    = 1'b0;
      start_s[0] = 1'b0;
      start_s[1] = 1'b0;
      for (int a = 0; a < 256; a++) mem[a] = {8{8'(a + 16)}};
      repeat (3) @(negedge clk);
      check("reset_outputs_a", out_vec[0], 0);
      check("reset_outputs_b", out_vec[1], 0);
      #1 reset_n = 1'b1;

      run_frame(0, 0, 1'b0);
      for (int a = 0; a < 256; a++) mem[a] = {$urandom, $urandom};
      run_frame(0, 3, 1'b0);
      run_frame(0, 2, 1'b0);
      run_frame(0, 1, 1'b1);

      // Abort during the row 1, word 1 read; the returning data must not be pushed.
      expect_frame(0);
      ready_mode = 0;
      pulse_start(0);
      cyc = 0;
      while (!(bus[0].enb && bus[0].addrb == 8'd3) && cyc < 500) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      check("reached_row1_word1", bus[0].enb && bus[0].addrb == 8'd3, 1'b1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("reset_mid_outputs", out_vec[0], 0);
      #1 reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("no_stale_push", bus[0].fifo_push, 1'b0);
      end
      exp_win[0].delete();
      exp_addr[0].delete();
      run_frame(0, 0, 1'b0);

      run_frame(1, 0, 1'b0);
      run_frame(1, 1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/window_row_ctrl.md
Name: window_row_ctrl

Overview:
- Sequencer for the 3-pixel window byte FIFO (64-bit push, 24-bit pop, 4-bit count, row-clear input) in the input layer.
- Reads image rows from block RAM port B, one 64-bit word (8 pixels) at a time, and pushes each word into the FIFO.
- Pops one 24-bit window per accepted valid/ready handshake to the processing stage.
- Clears the FIFO between rows and signals frame completion.

Parameters:
- ROW_WORDS, 2, 64-bit words per image row (row = 8*ROW_WORDS pixels); range 1..31.
- NUM_ROWS, 2, rows per frame; ROW_WORDS*NUM_ROWS <= 256.
- BASE_ADDR, 0, BRAM word address of row 0, word 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last window of the last row is popped
- enb  out  1  BRAM port-B read enable
- addrb  out  8  BRAM port-B word address
- doutb  in  64  BRAM read data; valid the cycle after enb
- fifo_data_in  out  64  FIFO push data (= doutb)
- fifo_push  out  1  FIFO push strobe
- fifo_pop  out  1  FIFO pop strobe
- fifo_one_row_complete  out  1  FIFO clear strobe
- fifo_data_o  in  24  FIFO head window
- fifo_count  in  4  FIFO byte count
- window_data  out  24  window to processing (= fifo_data_o)
- window_valid  out  1  window available
- window_ready  in  1  processing accepts window
- row_idx  out  8  current row, 0-based
- col_idx  out  8  index of the window at the head, 0..8*ROW_WORDS-3

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0; counters cleared; addrb=0.
- States:
  - IDLE: on start, assert fifo_one_row_complete for 1 cycle, then go to RUN. busy=1 from the cycle after start. start is ignored while not IDLE.
  - RUN:
    - Read issue: enb=1 when words_issued<ROW_WORDS, no read in flight and fifo_count<=7. addrb = BASE_ADDR + row_idx*ROW_WORDS + words_issued, modulo 256. Increment words_issued.
    - Read return: in-flight flag set by enb, cleared the next cycle. Push: fifo_push=1 exactly the cycle after enb; fifo_data_in=doutb (combinational). The fifo_count<=7 issue rule guarantees the push is accepted, since pops only lower the count.
    - Window output: window_valid = RUN & fifo_count>=3 & windows_left>0. fifo_pop = window_valid & window_ready. Each pop increments col_idx and decrements windows_left; windows_left starts at 8*ROW_WORDS-2 per row.
    - Simultaneous push and pop in one cycle are legal and both are taken.
    - When windows_left reaches 0 (last pop accepted), go to ROW_END. The 2 residual bytes are discarded.
  - ROW_END, 1 cycle: fifo_one_row_complete=1; window_valid=0; no enb.
    - If row_idx==NUM_ROWS-1: go to DONE.
    - Else: row_idx+1, col_idx=0, words_issued=0, windows_left reloaded; back to RUN.
  - DONE, 1 cycle: done=1, busy=0, then IDLE. row_idx and col_idx hold their last values until the next start.
- window_ready may stay high or toggle arbitrarily. A stalled window holds window_data and window_valid stable.
- enb is never asserted in IDLE, ROW_END or DONE. At most one read is outstanding.
- Counter widths: words_issued 6 bit, windows_left 8 bit. Address arithmetic truncates to 8 bits.
- reset_n assertion mid-frame aborts immediately. After release, an in-flight doutb must not produce a push.

Test Plan:
- Defaults, ready=1, BRAM word at addr a = {8{a[7:0]+8'h10}} byte-ramp pattern: 14 windows per row, 28 total. enb at addr 0,1 (row 0), then 2,3 (row 1). fifo_one_row_complete pulses 3 times (start, after each row). done pulses once.
- window_ready held 0 for 20 cycles after first window_valid: fifo_count settles at 15 or less, enb stays 0 while fifo_count>7, window_data stable. On release, 14 pops with col_idx 0..13 in order.
- ready toggling every cycle (1,0,1,0…): exactly one pop per high cycle. Window byte order matches consecutive pixels, e.g. bytes {p2,p1,p0} then {p3,p2,p1}.
- start pulsed while busy: ignored; the frame still completes with exactly 28 pops.
- reset_n low for 1 cycle during row 1, word 1 read: all outputs 0 next edge, no push from the stale doutb. A new start reruns from addr BASE_ADDR.
- ROW_WORDS=1, NUM_ROWS=3, BASE_ADDR=254: addresses 254, 255, 0 (wrap); 6 windows per row.
